pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor for wide operands. Splits an N-bit add into STAGES chunks, one chunk per clock stage, carry forwarded between stages. Accepts one operation per cycle. Sits in the arithmetic datapath wherever a wide combinational carry chain would limit clock frequency.

## Interface
- N, default 32: operand and result width; must be a multiple of STAGES.
- STAGES, default 4: pipeline depth and chunk count; chunk width W = N/STAGES; 1 ≤ STAGES ≤ N.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; one clock, no other clock domains.
- ce  input  1  clock enable; 0 freezes the whole pipeline.
- valid_in  input  1  operands on a, b, Cin, sub are valid this cycle.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- Cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: s = a + b + Cin; 1: s = a − b, computed as a + ~b + 1.
- valid_out  output  1  s and Cout are valid this cycle.
- s  output  N  sum/difference, modulo 2^N.
- Cout  output  1  carry out of bit N−1; for sub=1, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Capture: on a clk edge with ce=1, stage 0 registers a, ~b or b (by sub), effective carry (sub ? 1 : Cin) and valid_in.
- Stage k (0..STAGES−1) adds chunk k, bits [k·W +: W], of its operand copy plus the incoming carry. It registers the W-bit partial sum and chunk carry-out. The carry-out feeds stage k+1 on the next cycle.
- Skew registers: unconsumed high chunks of a/b travel with the operation. Deskew registers: already-computed low sum chunks are delayed so that all of s emerges in the same cycle.
- Output: s, Cout (carry of stage STAGES−1) and valid_out are registered at the last stage.
- Data registers load on every ce=1 edge regardless of valid_in. Only valid_out qualifies the outputs.
- s/Cout hold their last value while valid_out=0; a bench must not check them then.
- Operations never interact; each carries its own carry chain. Back-to-back operations at one per cycle are required.
- ce=0: every register, including valid bits, holds; inputs are ignored that cycle.
- STAGES=1: degenerates to a single registered N-bit adder.

## Timing
- Latency: exactly STAGES enabled clock edges from the capture edge to the edge that presents the result. A result captured at edge t appears after edge t+STAGES−1 when ce stays 1.
- Throughput: 1 operation/cycle; no bubbles are inserted.
- Reset values: valid_out=0, s=0, Cout=0, ovf=0; all internal valid, operand, sum and carry registers are 0.
- Reset takes effect immediately (asynchronous) and takes priority over ce. In-flight operations are discarded and never produce valid_out.
- First valid_out after reset deassertion comes no earlier than STAGES enabled edges after the first captured valid_in.
- ce toggling mid-flight only stretches latency in clock cycles. Results and order are unchanged.
- Critical path: one W-bit ripple plus carry register; no path spans more than one chunk.

## Configuration
- PIPE_ADDER_OVF_EN defined: port ovf exists. ovf = carry into bit N−1 XOR Cout, computed in the last stage and aligned with s. Reset value 0.
- PIPE_ADDER_OVF_EN undefined: ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst mid-stream with N=8, STAGES=2 and 2 ops in flight -> valid_out, s, Cout drop to 0 asynchronously; no valid_out follows after release until new inputs arrive.
- Carry across chunks: N=8, STAGES=2, a=0x0F, b=0x01, Cin=0 -> 2 cycles later s=0x10, Cout=0. Then a=0xFF, b=0x00, Cin=1 -> s=0x00, Cout=1.
- Subtract: a=0x05, b=0x07, sub=1 -> s=0xFE, Cout=0. Then a=0x07, b=0x05 -> s=0x02, Cout=1. Cin=1 has no effect in both cases.
- Throughput: N=32, STAGES=4, 100 back-to-back random valid ops -> 100 consecutive valid_out cycles, in order, each matching a+b+Cin modulo 2^32 against a reference model, latency 4.
- Stall: ce held low 3 cycles while 2 ops are in flight -> outputs and valid_out frozen; results appear 3 cycles later than without the stall, values unchanged.
- Overflow (PIPE_ADDER_OVF_EN): N=8, a=0x7F, b=0x01 -> s=0x80, ovf=1. a=0x80, b=0x01, sub=1 -> s=0x7F, ovf=1. a=0x10, b=0x20 -> ovf=0.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder; master drives operands, slave returns results.
// The ovf wire exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int N = 32
);
  logic         ce;
  logic         valid_in;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         Cin;
  logic         sub;
  logic         valid_out;
  logic [N-1:0] s;
  logic         Cout;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;

  modport master (output ce, valid_in, a, b, Cin, sub, input valid_out, s, Cout, ovf);
  modport slave  (input ce, valid_in, a, b, Cin, sub, output valid_out, s, Cout, ovf);
`else
  modport master (output ce, valid_in, a, b, Cin, sub, input valid_out, s, Cout);
  modport slave  (input ce, valid_in, a, b, Cin, sub, output valid_out, s, Cout);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one W-bit chunk per stage, carry registered between stages.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output io.ovf.
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave io
);
  localparam int W    = N / STAGES;
  localparam int LAST = STAGES - 1;

  // Each stage keeps full-width copies; bits a stage no longer needs have no fanout and are pruned.
  logic [N-1:0] r_a     [STAGES];
  logic [N-1:0] r_b     [STAGES];
  logic [N-1:0] r_sum   [STAGES];
  logic         r_carry [STAGES];
  logic         r_valid [STAGES];

  logic [N-1:0] w_a       [STAGES];
  logic [N-1:0] w_b       [STAGES];
  logic [N-1:0] w_sum     [STAGES];
  logic         w_cin     [STAGES];
  logic         w_vin     [STAGES];
  logic [W:0]   w_add     [STAGES];
  logic [N-1:0] w_sum_nxt [STAGES];

  always_comb begin
    // NOTE: every always_comb target is assigned before any conditional use, so no latch is inferred.
    w_a[0]   = io.a;
    w_b[0]   = io.sub ? ~io.b : io.b;
    w_cin[0] = io.sub ? 1'b1 : io.Cin;
    w_vin[0] = io.valid_in;
    w_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]   = r_a[k-1];
      w_b[k]   = r_b[k-1];
      w_cin[k] = r_carry[k-1];
      w_vin[k] = r_valid[k-1];
      w_sum[k] = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, w_a[k][k*W +: W]} + {1'b0, w_b[k][k*W +: W]} + {{W{1'b0}}, w_cin[k]};
      w_sum_nxt[k]            = w_sum[k];
      w_sum_nxt[k][k*W +: W]  = w_add[k][W-1:0];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Carry into the MSB is a ^ b ^ sum at that bit; overflow is that carry differing from Cout.
  assign w_ovf = w_a[LAST][N-1] ^ w_b[LAST][N-1] ^ w_add[LAST][W-1] ^ w_add[LAST][W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the pipeline arrays are reset too, because in-flight operations must be discarded.
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_valid[k] <= 1'b0;
      end
`ifdef PIPE_ADDER_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else if (io.ce) begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= w_a[k];
        r_b[k]     <= w_b[k];
        r_sum[k]   <= w_sum_nxt[k];
        r_carry[k] <= w_add[k][W];
        r_valid[k] <= w_vin[k];
      end
`ifdef PIPE_ADDER_OVF_EN
      r_ovf <= w_ovf;
`endif
    end
  end

  assign io.s         = r_sum[LAST];
  assign io.Cout      = r_carry[LAST];
  assign io.valid_out = r_valid[LAST];
`ifdef PIPE_ADDER_OVF_EN
  assign io.ovf       = r_ovf;
`endif

endmodule
